// File: rtl/alu_issue_stage_pkg.sv
// Shared RV32I(+M subset) encodings, ALU op codes and the decoded issue bundle
// used by the issue stage and the execute ALU.
package alu_issue_stage_pkg;

    localparam int XLEN       = 32;
    localparam int SKID_DEPTH = 2;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SLL = 4'h5;
    localparam logic [3:0] ALU_SRA = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;
    localparam logic [3:0] ALU_EQ  = 4'h8;
    localparam logic [3:0] ALU_NE  = 4'h9;
    localparam logic [3:0] ALU_GE  = 4'hA;
    localparam logic [3:0] ALU_LTU = 4'hB;
    localparam logic [3:0] ALU_GEU = 4'hC;
    localparam logic [3:0] ALU_MUL = 4'hD;
    localparam logic [3:0] ALU_DIV = 4'hE;
    localparam logic [3:0] ALU_REM = 4'hF;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [XLEN-1:0] src_a;
        logic [XLEN-1:0] src_b;
        logic [3:0]      alu_op;
        logic [4:0]      rd;
        logic            rd_we;
        logic            branch;
        logic            illegal;
    } issue_t;

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'h000};
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream/downstream handshake bundle of the ALU issue stage.
interface alu_issue_stage_if;
    import alu_issue_stage_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [31:0]     in_pc;
    logic [31:0]     in_rs1_data;
    logic [31:0]     in_rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_src_a;
    logic [XLEN-1:0] out_src_b;
    logic [3:0]      out_alu_op;
    logic [4:0]      out_rd;
    logic            out_rd_we;
    logic            out_branch;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_src_a, out_src_b, out_alu_op, out_rd,
               out_rd_we, out_branch, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_src_a, out_src_b, out_alu_op, out_rd,
               out_rd_we, out_branch, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage_alu_op_decode.sv
// Combinational decode of one instruction into ALU operands, op code and side-band.
module alu_op_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output issue_t      dec
);

    logic [6:0]  opcode_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [31:0] src_a_s;
    logic [31:0] src_b_s;
    logic [3:0]  op_s;
    logic        wr_s;
    logic        br_s;
    logic        ill_s;
    logic        unused_rs1_idx_s;

    assign opcode_s = instr[6:0];
    assign f3_s     = instr[14:12];
    assign f7_s     = instr[31:25];
    // Register indices are resolved upstream; only the read data matters here.
    assign unused_rs1_idx_s = ^instr[19:15];

    // Field extraction and op mapping per major opcode.
    always_comb begin
        src_a_s = 32'h0000_0000;
        src_b_s = 32'h0000_0000;
        op_s    = ALU_ADD;
        wr_s    = 1'b0;
        br_s    = 1'b0;
        ill_s   = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                src_a_s = rs1_data;
                src_b_s = rs2_data;
                wr_s    = 1'b1;
                case (f7_s)
                    F7_BASE: begin
                        case (f3_s)
                            F3_ADD:  op_s = ALU_ADD;
                            F3_SLL: begin
                                op_s    = ALU_SLL;
                                src_b_s = {27'h0000000, rs2_data[4:0]};
                            end
                            F3_SLT:  op_s = ALU_SLT;
                            F3_SLTU: op_s = ALU_LTU;
                            F3_XOR:  op_s = ALU_XOR;
                            F3_OR:   op_s = ALU_OR;
                            F3_AND:  op_s = ALU_AND;
                            default: ill_s = 1'b1;
                        endcase
                    end
                    F7_ALT: begin
                        case (f3_s)
                            F3_ADD:  op_s = ALU_SUB;
                            F3_SR: begin
                                op_s    = ALU_SRA;
                                src_b_s = {27'h0000000, rs2_data[4:0]};
                            end
                            default: ill_s = 1'b1;
                        endcase
                    end
                    F7_MULDIV: begin
                        case (f3_s)
                            F3_MUL:  op_s = ALU_MUL;
                            F3_DIV:  op_s = ALU_DIV;
                            F3_REM:  op_s = ALU_REM;
                            default: ill_s = 1'b1;
                        endcase
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                src_a_s = rs1_data;
                src_b_s = imm_i(instr);
                wr_s    = 1'b1;
                case (f3_s)
                    F3_ADD:  op_s = ALU_ADD;
                    F3_SLT:  op_s = ALU_SLT;
                    F3_SLTU: op_s = ALU_LTU;
                    F3_XOR:  op_s = ALU_XOR;
                    F3_OR:   op_s = ALU_OR;
                    F3_AND:  op_s = ALU_AND;
                    F3_SLL: begin
                        op_s    = ALU_SLL;
                        src_b_s = {27'h0000000, instr[24:20]};
                        ill_s   = (f7_s != F7_BASE);
                    end
                    F3_SR: begin
                        op_s    = ALU_SRA;
                        src_b_s = {27'h0000000, instr[24:20]};
                        ill_s   = (f7_s != F7_ALT);
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_LUI: begin
                src_b_s = imm_u(instr);
                wr_s    = 1'b1;
            end
            OPC_AUIPC: begin
                src_a_s = pc;
                src_b_s = imm_u(instr);
                wr_s    = 1'b1;
            end
            OPC_JAL: begin
                src_a_s = pc;
                src_b_s = 32'h0000_0004;
                wr_s    = 1'b1;
            end
            OPC_JALR: begin
                src_a_s = pc;
                src_b_s = 32'h0000_0004;
                wr_s    = 1'b1;
                ill_s   = (f3_s != 3'b000);
            end
            OPC_LOAD: begin
                src_a_s = rs1_data;
                src_b_s = imm_i(instr);
                wr_s    = 1'b1;
                ill_s   = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
            end
            OPC_STORE: begin
                src_a_s = rs1_data;
                src_b_s = imm_s(instr);
                ill_s   = (f3_s[2] == 1'b1) || (f3_s == 3'b011);
            end
            OPC_BRANCH: begin
                src_a_s = rs1_data;
                src_b_s = rs2_data;
                br_s    = 1'b1;
                case (f3_s)
                    F3_BEQ:  op_s = ALU_EQ;
                    F3_BNE:  op_s = ALU_NE;
                    F3_BLT:  op_s = ALU_SLT;
                    F3_BGE:  op_s = ALU_GE;
                    F3_BLTU: op_s = ALU_LTU;
                    F3_BGEU: op_s = ALU_GEU;
                    default: ill_s = 1'b1;
                endcase
            end
            default: ill_s = 1'b1;
        endcase
    end

    // Illegal encodings collapse to a harmless ADD 0+0 with no write-back.
    always_comb begin
        dec.rd      = instr[11:7];
        dec.illegal = ill_s;
        if (ill_s) begin
            dec.src_a  = 32'h0000_0000;
            dec.src_b  = 32'h0000_0000;
            dec.alu_op = ALU_ADD;
            dec.rd_we  = 1'b0;
            dec.branch = 1'b0;
        end else begin
            dec.src_a  = src_a_s;
            dec.src_b  = src_b_s;
            dec.alu_op = op_s;
            dec.rd_we  = wr_s && (instr[11:7] != 5'd0);
            dec.branch = br_s;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes each accepted instruction and holds it in a
// 2-entry skid buffer so in_ready can be driven straight from a flop.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input logic             clk,
    input logic             areset,
    alu_issue_stage_if.slave bus
);

    issue_t     dec_s;
    issue_t     head_r, head_n;
    issue_t     tail_r, tail_n;
    logic [1:0] count_r, count_n;
    logic       in_ready_r;
    logic       out_valid_r;
    logic       push_s;
    logic       pop_s;

    alu_op_decode u_decode (
        .instr    (bus.in_instr),
        .pc       (bus.in_pc),
        .rs1_data (bus.in_rs1_data),
        .rs2_data (bus.in_rs2_data),
        .dec      (dec_s)
    );

    assign push_s = bus.in_valid && in_ready_r;
    assign pop_s  = out_valid_r && bus.out_ready;

    // Next-state of the head/tail pair; head is always the oldest entry.
    always_comb begin
        head_n  = head_r;
        tail_n  = tail_r;
        count_n = count_r;
        if (bus.flush) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        head_n  = dec_s;
                        count_n = 2'd1;
                    end else begin
                        count_n = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_n = dec_s;
                    end else if (push_s) begin
                        tail_n  = dec_s;
                        count_n = 2'd2;
                    end else if (pop_s) begin
                        count_n = 2'd0;
                    end else begin
                        count_n = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_n  = tail_r;
                        count_n = 2'd1;
                    end else begin
                        count_n = 2'd2;
                    end
                end
                default: count_n = 2'd0;
            endcase
        end
    end

    // Buffer state and the registered handshake flags.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            head_r      <= head_n;
            tail_r      <= tail_n;
            count_r     <= count_n;
            in_ready_r  <= (count_n != 2'(SKID_DEPTH));
            out_valid_r <= (count_n != 2'd0);
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_src_a   = head_r.src_a;
    assign bus.out_src_b   = head_r.src_b;
    assign bus.out_alu_op  = head_r.alu_op;
    assign bus.out_rd      = head_r.rd;
    assign bus.out_rd_we   = head_r.rd_we;
    assign bus.out_branch  = head_r.branch;
    assign bus.out_illegal = head_r.illegal;

endmodule
